tile_spawner: RTL and testbench

TILE_SPAWNER -- requirements
Module: tile_spawner

---
 rtl/game_pkg.sv | 32 +++
 rtl/lfsr16.sv | 32 +++
 rtl/tile_spawner.sv | 157 +++++++++++++++
 tb/tb_tile_spawner.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
// Module      : game_pkg
// Description : Shared board geometry, spawner state encoding and LFSR taps.
// Revision    : 1.0 - initial release
// ============================================================================
package game_pkg;

    localparam int GRID_N = 4;
    localparam int CELL_W = 4;
    localparam int NCELLS = GRID_N * GRID_N;
    localparam int IDX_W  = 4;
    localparam int CNT_W  = 5;

    // x^16 + x^14 + x^13 + x^11 + 1, left-shifting: taps on bits 15, 13, 12, 10
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {
        SP_IDLE  = 2'd0,
        SP_SCAN  = 2'd1,
        SP_PLACE = 2'd2,
        SP_DONE  = 2'd3
    } spawn_state_e;

    typedef logic [0:GRID_N-1][0:GRID_N-1][CELL_W-1:0] grid_t;

    function automatic logic lfsr_feedback(input logic [15:0] s);
        return ^(s & LFSR_TAPS);
    endfunction

endpackage
`default_nettype wire

// File: rtl/lfsr16.sv
`default_nettype none
// ============================================================================
// Module      : lfsr16
// Description : 16-bit Fibonacci LFSR, shifts left every cycle, reloads seed.
// Revision    : 1.0 - initial release
// ============================================================================
module lfsr16
    import game_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] seed,
    output logic [15:0] q
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    assign lfsr_d = {lfsr_q[14:0], lfsr_feedback(lfsr_q)};

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_q <= seed;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign q = lfsr_q;

endmodule
`default_nettype wire

// File: rtl/tile_spawner.sv
`default_nettype none
// ============================================================================
// Module      : tile_spawner
// Description : Places one random 2/4 tile into the first empty cell found
//               by a wrapping linear probe from a random start index.
// Revision    : 1.0 - initial release
// ============================================================================
module tile_spawner
    import game_pkg::*;
#(
    parameter logic [15:0] LFSR_SEED  = 16'hACE1,
    parameter int          FOUR_SLOTS = 2
) (
    input  logic                                         clk,
    input  logic                                         reset,
    input  logic                                         start,
    input  logic [0:GRID_N-1][0:GRID_N-1][CELL_W-1:0]    grid_in,
    output logic [0:GRID_N-1][0:GRID_N-1][CELL_W-1:0]    grid_out,
    output logic                                         busy,
    output logic                                         done,
    output logic                                         full
);

    localparam logic [4:0]       FOUR_THR  = 5'(FOUR_SLOTS);
    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(NCELLS - 1);

    spawn_state_e      state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [CELL_W-1:0] value_q, value_d;
    grid_t             board_q, board_d;
    grid_t             grid_out_q, grid_out_d;
    logic              full_q, full_d;

    logic [15:0]       lfsr_q;
    logic [CELL_W-1:0] probe_cell;
    logic              probe_hit;
    logic              last_probe;
    logic              four_tile;
    logic [7:0]        lfsr_unused;

    lfsr16 u_lfsr (
        .clk   (clk),
        .reset (reset),
        .seed  (LFSR_SEED),
        .q     (lfsr_q)
    );

    // Only the low byte selects start index and tile value
    assign lfsr_unused = lfsr_q[15:8];

    assign probe_cell = board_q[idx_q[3:2]][idx_q[1:0]];
    assign probe_hit  = (probe_cell == '0);
    assign last_probe = (count_q == LAST_CNT);
    assign four_tile  = ({1'b0, lfsr_q[7:4]} < FOUR_THR);

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= SP_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            SP_IDLE:  if (start) state_d = SP_SCAN;
            SP_SCAN: begin
                if (probe_hit) begin
                    state_d = SP_PLACE;
                end else if (last_probe) begin
                    state_d = SP_DONE;
                end
            end
            SP_PLACE: state_d = SP_DONE;
            SP_DONE:  state_d = SP_IDLE;
            default:  state_d = SP_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------------
    always_comb begin
        busy = (state_q != SP_IDLE);
        done = (state_q == SP_DONE);
    end

    // ------------------------------------------------------------------------
    // Datapath next state; grid_out is loaded on entry to DONE so it is
    // already valid during the done pulse.
    // ------------------------------------------------------------------------
    always_comb begin
        idx_d      = idx_q;
        count_d    = count_q;
        value_d    = value_q;
        board_d    = board_q;
        grid_out_d = grid_out_q;
        full_d     = full_q;
        case (state_q)
            SP_IDLE: begin
                if (start) begin
                    board_d = grid_in;
                    idx_d   = lfsr_q[3:0];
                    value_d = four_tile ? CELL_W'(2) : CELL_W'(1);
                    count_d = '0;
                    full_d  = 1'b0;
                end
            end
            SP_SCAN: begin
                if (!probe_hit) begin
                    idx_d   = idx_q + 1'b1;
                    count_d = count_q + 1'b1;
                    if (last_probe) begin
                        full_d     = 1'b1;
                        grid_out_d = board_q;
                    end
                end
            end
            SP_PLACE: begin
                board_d[idx_q[3:2]][idx_q[1:0]] = value_q;
                grid_out_d                      = board_d;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q      <= '0;
            count_q    <= '0;
            value_q    <= '0;
            board_q    <= '0;
            grid_out_q <= '0;
            full_q     <= 1'b0;
        end else begin
            idx_q      <= idx_d;
            count_q    <= count_d;
            value_q    <= value_d;
            board_q    <= board_d;
            grid_out_q <= grid_out_d;
            full_q     <= full_d;
        end
    end

    assign grid_out = grid_out_q;
    assign full     = full_q;

endmodule
`default_nettype wire

// File: tb/tb_tile_spawner.sv
`default_nettype none
// ============================================================================
// Module      : tb_tile_spawner
// Description : Directed and soak bench for tile_spawner against a
//               spawn-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tile_spawner;

    localparam logic [15:0] SEED  = 16'hACE1;
    localparam int          FOURS = 2;

    localparam logic [63:0] B_EMPTY   = 64'h0000_0000_0000_0000;
    localparam logic [63:0] B_ONE_HOLE = 64'h0111_1111_1111_1111;
    localparam logic [63:0] B_ALL1    = 64'h1111_1111_1111_1111;
    localparam logic [63:0] B_ALL3    = 64'h3333_3333_3333_3333;
    localparam logic [63:0] B_T1      = 64'h0100_0000_0000_0000;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic [0:3][0:3][3:0] grid_in = '0;
    logic [0:3][0:3][3:0] grid_out;
    logic busy, done, full;

    always #5 clk = ~clk;

    tile_spawner #(
        .LFSR_SEED  (SEED),
        .FOUR_SLOTS (FOURS)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .grid_in  (grid_in),
        .grid_out (grid_out),
        .busy     (busy),
        .done     (done),
        .full     (full)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Reference model: one whole spawn is resolved at the start edge; the
    // model then only remembers on which edge its done pulse must appear.
    // ------------------------------------------------------------------------
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        int   exps [4] = '{16, 14, 13, 11};
        logic fb = 1'b0;
        foreach (exps[i]) fb ^= s[exps[i] - 1];
        return {s[14:0], fb};
    endfunction

    int                   edge_n = 0;
    bit                   m_init = 0;
    logic [15:0]          m_lfsr;
    int                   m_done_edge = -10;
    logic [0:3][0:3][3:0] m_cap, m_res, m_gout;
    bit                   m_res_full, m_full, m_busy, m_done;

    always @(posedge clk) begin : model
        int idx0, k, j;
        logic [3:0] v;
        edge_n++;
        if (reset) begin
            m_init      = 1;
            m_lfsr      = SEED;
            m_done_edge = -10;
            m_gout      = '0;
            m_full      = 0;
            m_busy      = 0;
            m_done      = 0;
        end else if (m_init) begin
            m_done = (edge_n == m_done_edge);
            if (m_done) begin
                m_gout = m_res;
                m_full = m_res_full;
            end
            if (edge_n >= m_done_edge + 2 && start) begin
                m_cap = grid_in;
                m_res = grid_in;
                idx0  = int'(m_lfsr[3:0]);
                v     = (m_lfsr[7:4] < FOURS) ? 4'd2 : 4'd1;
                j     = 0;
                for (int p = 0; p < 16; p++) begin
                    k = (idx0 + p) % 16;
                    if (m_cap[k / 4][k % 4] == 4'd0) begin
                        j = p + 1;
                        break;
                    end
                end
                if (j == 0) begin
                    m_res_full  = 1;
                    m_done_edge = edge_n + 16;
                end else begin
                    m_res_full  = 0;
                    k           = (idx0 + j - 1) % 16;
                    m_res[k / 4][k % 4] = v;
                    m_done_edge = edge_n + j + 1;
                end
                m_full = 0;
            end
            m_busy = (edge_n <= m_done_edge);
            m_lfsr = lfsr_next(m_lfsr);
        end
    end

    // ------------------------------------------------------------------------
    // Compare process, half a cycle after each active edge
    // ------------------------------------------------------------------------
    bit     soak = 0;
    int     soak_dones = 0;
    longint soak_spawns = 0;
    longint soak_fours = 0;

    always @(negedge clk) begin : compare
        int changed, overwrote;
        logic [3:0] newv;
        if (m_init) begin
            check("done", done, m_done);
            check("busy", busy, m_busy);
            check("full", full, m_full);
            check("grid_out", grid_out, m_gout);
            if (done && m_done && soak) soak_dones++;
            if (done && m_done && !m_full) begin
                changed   = 0;
                overwrote = 0;
                newv      = 4'd0;
                for (int k = 0; k < 16; k++) begin
                    if (grid_out[k / 4][k % 4] != m_cap[k / 4][k % 4]) begin
                        changed++;
                        if (m_cap[k / 4][k % 4] != 4'd0) overwrote++;
                        newv = grid_out[k / 4][k % 4];
                    end
                end
                check("one_cell_changed", changed, 1);
                check("no_overwrite", overwrote, 0);
                check("new_tile_2_or_4", (newv == 4'd1 || newv == 4'd2), 1);
                if (soak) begin
                    soak_spawns++;
                    if (newv == 4'd2) soak_fours++;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus; every task is entered and left on a falling edge
    // ------------------------------------------------------------------------
    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic spawn(input logic [63:0] g, output int n);
        grid_in = g;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        grid_in = ~g;
        n = 1;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin : stim
        int n, dcount, cyc;
        @(negedge clk);
        check("reset_grid_out", grid_out, 64'h0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_full", full, 0);

        // empty board: seed gives idx 1 and a 2-tile
        do_reset();
        spawn(B_EMPTY, n);
        check("t1_latency", n, 3);
        check("t1_grid", grid_out, B_T1);
        check("t1_full", full, 0);

        // single hole at [0][0] is the 16th probe after wrapping
        do_reset();
        spawn(B_ONE_HOLE, n);
        check("t2_latency", n, 18);
        check("t2_grid", grid_out, B_ALL1);
        check("t2_full", full, 0);

        do_reset();
        spawn(B_ALL3, n);
        check("t3_latency", n, 17);
        check("t3_full", full, 1);
        check("t3_grid", grid_out, B_ALL3);
        repeat (3) @(negedge clk);
        check("t3_full_held", full, 1);

        // abort a long spawn with reset in its cycle 5
        do_reset();
        grid_in = B_ONE_HOLE;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        dcount  = 0;
        repeat (4) begin
            dcount += int'(done);
            @(negedge clk);
        end
        dcount += int'(done);
        reset = 1'b1;
        @(negedge clk);
        dcount += int'(done);
        check("t4_no_done", dcount, 0);
        check("t4_grid_cleared", grid_out, 64'h0);
        check("t4_not_busy", busy, 0);
        reset = 1'b0;
        spawn(B_EMPTY, n);
        check("t4_restart_latency", n, 3);
        check("t4_restart_grid", grid_out, B_T1);

        // start pulsed again in cycles 2-4 is ignored
        do_reset();
        grid_in = B_ONE_HOLE;
        start   = 1'b1;
        dcount  = 0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            start   = (c >= 2 && c <= 4);
            dcount += int'(done);
        end
        start = 1'b0;
        check("t5_single_done", dcount, 1);
        check("t5_grid", grid_out, B_ALL1);

        // soak: start held, board re-randomised every cycle
        soak  = 1;
        start = 1'b1;
        cyc   = 0;
        while (soak_dones < 10000 && cyc < 80000) begin
            for (int k = 0; k < 16; k++)
                grid_in[k / 4][k % 4] = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check("soak_completed", soak_dones >= 10000, 1);
        repeat (20) @(negedge clk);
        soak = 0;
        check("soak_four_rate", (soak_spawns > 0) &&
              (soak_fours * 1000 >= 115 * soak_spawns) &&
              (soak_fours * 1000 <= 135 * soak_spawns), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
